// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : display_scan_ctrl
// Purpose  : Four-digit 7-segment scan controller with dead-time blanking,
//            leading-zero suppression, PWM brightness and frame blink.
// Revision : 1.0 - initial release
// ============================================================================
module display_scan_ctrl #(
  parameter int          REFRESH_DIV  = 2500,
  parameter int          BLANK_CYCLES = 8,
  parameter int          BLINK_FRAMES = 250,
  parameter logic [6:0]  ZERO_PATTERN = 7'h3F
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [6:0] seg_0,
  input  logic [6:0] seg_1,
  input  logic [6:0] seg_2,
  input  logic [6:0] seg_3,
  input  logic       lz_en,
  input  logic       blink_req,
  input  logic [2:0] brightness,
  output logic [6:0] seg_out,
  output logic [3:0] digit_sel,
  output logic       frame_tick
);

  localparam int c_slot_w  = $clog2(REFRESH_DIV);
  localparam int c_blink_w = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [c_slot_w-1:0]  r_slot_cnt;
  logic [1:0]           r_digit_idx;
  logic [2:0]           r_pwm_cnt;
  logic [c_blink_w-1:0] r_blink_cnt;
  logic                 r_blink_phase;
  logic [3:0][6:0]      r_snap;
  logic [6:0]           r_seg_out;
  logic [3:0]           r_digit_sel;
  logic                 r_frame_tick;

  logic                 w_slot_wrap;
  logic                 w_frame_wrap;
  logic                 w_blink_last;
  logic [3:0]           w_supp;
  logic                 w_drive;

  always_comb begin
    w_slot_wrap  = (r_slot_cnt == c_slot_w'(REFRESH_DIV - 1));
    w_frame_wrap = w_slot_wrap && (r_digit_idx == 2'd3);
    w_blink_last = (r_blink_cnt == c_blink_w'(BLINK_FRAMES - 1));

    // Suppression chains downward from the most significant digit only.
    w_supp    = 4'b0000;
    w_supp[3] = lz_en && (r_snap[3] == ZERO_PATTERN);
    w_supp[2] = w_supp[3] && (r_snap[2] == ZERO_PATTERN);
    w_supp[1] = w_supp[2] && (r_snap[1] == ZERO_PATTERN);

    w_drive = (r_slot_cnt >= c_slot_w'(BLANK_CYCLES)) &&
              (r_pwm_cnt <= brightness) &&
              r_blink_phase &&
              !w_supp[r_digit_idx];
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_slot_cnt  <= '0;
      r_digit_idx <= 2'd0;
      r_pwm_cnt   <= 3'd0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 3'd1;
      if (w_slot_wrap) begin
        r_slot_cnt  <= '0;
        r_digit_idx <= r_digit_idx + 2'd1;
      end else begin
        r_slot_cnt  <= r_slot_cnt + c_slot_w'(1);
      end
    end
  end

  // Capture all digits on the last cycle of the frame so a frame never tears.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_snap <= '0;
    end else if (w_frame_wrap) begin
      r_snap <= {seg_3, seg_2, seg_1, seg_0};
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if (!blink_req) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if (w_frame_wrap) begin
      if (w_blink_last) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= !r_blink_phase;
      end else begin
        r_blink_cnt   <= r_blink_cnt + c_blink_w'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_seg_out    <= 7'd0;
      r_digit_sel  <= 4'd0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_frame_wrap;
      if (w_drive) begin
        r_seg_out   <= r_snap[r_digit_idx];
        r_digit_sel <= 4'b0001 << r_digit_idx;
      end else begin
        r_seg_out   <= 7'd0;
        r_digit_sel <= 4'd0;
      end
    end
  end

  assign seg_out    = r_seg_out;
  assign digit_sel  = r_digit_sel;
  assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_scan_ctrl
// Purpose  : Directed self-checking bench for display_scan_ctrl
//            (REFRESH_DIV=16, BLANK_CYCLES=2, BLINK_FRAMES=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_scan_ctrl;

  logic       clk;
  logic       nrst;
  logic [6:0] seg_0, seg_1, seg_2, seg_3;
  logic       lz_en;
  logic       blink_req;
  logic [2:0] brightness;
  logic [6:0] seg_out;
  logic [3:0] digit_sel;
  logic       frame_tick;

  int checks;
  int errors;
  int k;

  display_scan_ctrl #(
    .REFRESH_DIV  (16),
    .BLANK_CYCLES (2),
    .BLINK_FRAMES (2),
    .ZERO_PATTERN (7'h3F)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .seg_0      (seg_0),
    .seg_1      (seg_1),
    .seg_2      (seg_2),
    .seg_3      (seg_3),
    .lz_en      (lz_en),
    .blink_req  (blink_req),
    .brightness (brightness),
    .seg_out    (seg_out),
    .digit_sel  (digit_sel),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  // k counts rising edges since the last reset release; outputs seen after
  // edge k reflect counter state k-1 (slot=(k-1)%16, digit=((k-1)/16)%4).
  task automatic go_to(input int target);
    while (k < target) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] sel, input logic [6:0] seg);
    chk({tag, ".sel"}, {28'd0, digit_sel}, {28'd0, sel});
    chk({tag, ".seg"}, {25'd0, seg_out}, {25'd0, seg});
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    k          = 0;
    nrst       = 1'b0;
    seg_0      = 7'h06;
    seg_1      = 7'h5B;
    seg_2      = 7'h4F;
    seg_3      = 7'h66;
    lz_en      = 1'b0;
    blink_req  = 1'b0;
    brightness = 3'd7;

    #12;
    chk_out("reset", 4'b0000, 7'h00);
    chk("reset.tick", {31'd0, frame_tick}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    k = 0;

    // Frame 1 shows the zeroed snapshot.
    go_to(20);
    chk("f1.seg", {25'd0, seg_out}, 32'h0);
    go_to(63);
    chk("f1.tick_before", {31'd0, frame_tick}, 32'd0);
    go_to(64);
    chk("f1.tick", {31'd0, frame_tick}, 32'd1);
    go_to(65);
    chk_out("f2.d0_blank0", 4'b0000, 7'h00);
    chk("f2.tick_clear", {31'd0, frame_tick}, 32'd0);
    go_to(66);
    chk_out("f2.d0_blank1", 4'b0000, 7'h00);
    go_to(67);
    chk_out("f2.d0_first", 4'b0001, 7'h06);
    go_to(80);
    chk_out("f2.d0_last", 4'b0001, 7'h06);
    go_to(81);
    chk_out("f2.d1_blank", 4'b0000, 7'h00);
    go_to(83);
    chk_out("f2.d1", 4'b0010, 7'h5B);
    go_to(99);
    chk_out("f2.d2", 4'b0100, 7'h4F);
    go_to(115);
    chk_out("f2.d3", 4'b1000, 7'h66);
    go_to(128);
    chk("f2.tick", {31'd0, frame_tick}, 32'd1);

    // Mid-frame input change shows up only in the following frame.
    go_to(131);
    seg_0 = 7'h7D;
    go_to(139);
    chk_out("tear.same_frame", 4'b0001, 7'h06);
    go_to(195);
    chk_out("tear.next_frame", 4'b0001, 7'h7D);

    // Leading-zero suppression.
    lz_en = 1'b1;
    seg_3 = 7'h3F;
    seg_2 = 7'h3F;
    seg_1 = 7'h06;
    seg_0 = 7'h3F;
    go_to(259);
    chk_out("lz.d0", 4'b0001, 7'h3F);
    go_to(275);
    chk_out("lz.d1", 4'b0010, 7'h06);
    go_to(291);
    chk_out("lz.d2_dark", 4'b0000, 7'h00);
    go_to(307);
    chk_out("lz.d3_dark", 4'b0000, 7'h00);
    seg_3 = 7'h06;
    go_to(387);
    chk_out("lz2.d0", 4'b0001, 7'h3F);
    go_to(419);
    chk_out("lz2.d2_zero_shown", 4'b0100, 7'h3F);
    go_to(435);
    chk_out("lz2.d3", 4'b1000, 7'h06);

    // PWM brightness: pwm_cnt equals state index mod 8.
    brightness = 3'd1;
    go_to(451);
    chk_out("pwm1.pwm2_off", 4'b0000, 7'h00);
    go_to(457);
    chk_out("pwm1.pwm0_on", 4'b0001, 7'h3F);
    go_to(458);
    chk_out("pwm1.pwm1_on", 4'b0001, 7'h3F);
    go_to(459);
    chk_out("pwm1.pwm2_off_b", 4'b0000, 7'h00);
    brightness = 3'd0;
    go_to(473);
    chk_out("pwm0.pwm0_on", 4'b0010, 7'h06);
    go_to(474);
    chk_out("pwm0.pwm1_off", 4'b0000, 7'h00);
    brightness = 3'd7;

    // Blink: phase toggles at frame wraps 576 (off) and 704 (on), 832 (off).
    blink_req = 1'b1;
    go_to(570);
    chk_out("blink.on_first", 4'b1000, 7'h06);
    go_to(580);
    chk_out("blink.off_a", 4'b0000, 7'h00);
    go_to(691);
    chk_out("blink.off_b", 4'b0000, 7'h00);
    go_to(707);
    chk_out("blink.on_again", 4'b0001, 7'h3F);
    go_to(771);
    chk_out("blink.on_second", 4'b0001, 7'h3F);
    go_to(835);
    chk_out("blink.off_again", 4'b0000, 7'h00);
    blink_req = 1'b0;
    go_to(836);
    chk_out("blink.drop_edge", 4'b0000, 7'h00);
    go_to(837);
    chk_out("blink.drop_on", 4'b0001, 7'h3F);

    // Asynchronous reset in the middle of a digit-2 slot.
    go_to(870);
    chk_out("rst.pre", 4'b0100, 7'h3F);
    #2;
    nrst = 1'b0;
    #1;
    chk_out("rst.async", 4'b0000, 7'h00);
    chk("rst.async_tick", {31'd0, frame_tick}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    k = 0;
    go_to(2);
    chk_out("rst.resume_blank", 4'b0000, 7'h00);
    go_to(3);
    chk_out("rst.resume_d0", 4'b0001, 7'h00);
    go_to(64);
    chk("rst.tick", {31'd0, frame_tick}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
